keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Matrix-keypad front end that drives a 4x4 keypad's row lines and senses its column lines. It debounces presses and produces the `key` code and `button_pressed` level consumed by the keypad-entry accumulator, which edge-detects `button_pressed` and samples `key`. It sits between the board keypad pins and the entry logic, on the 12 MHz `hwclk` domain.

## Interface
- `SCAN_DIV`, 12000, clock cycles each row is driven (1 ms at 12 MHz); must be ≥ 4.
- `DEBOUNCE_FRAMES`, 5, consecutive identical full-scan frames required to assert or release a press; must be ≥ 1.
- `hwclk` input 1: system clock, 12 MHz.
- `reset_n` input 1: asynchronous, active-low reset; one clock, no other clock domain.
- `col` input 4: keypad columns, active-low (externally pulled up), asynchronous to `hwclk`.
- `row` output 4: keypad rows, active-low, exactly one bit low at any time.
- `key` output 8: code of the debounced key; valid whenever `button_pressed`=1.
- `button_pressed` output 1: high while a debounced key is held.

## Operation
- Key map as [row][col] → code:
  - Row 0: 1, 2, 3, A=10.
  - Row 1: 4, 5, 6, B=11.
  - Row 2: 7, 8, 9, C=12.
  - Row 3: *=14, 0, #=15, D=13.
  - `key[7:4]` is always 0.
- `col` passes through a 2-flop synchronizer. All decisions use the synchronized value.
- Row scan:
  - Row r is driven low for `SCAN_DIV` cycles, then r+1; row 3 wraps to row 0.
  - Synchronized `col` is sampled on the last cycle of each dwell.
  - The row-3 sample is the frame end.
- Frame candidate: the lowest-indexed active (row, col) pair sampled in the frame, scanning rows first, then columns. If no column was active in the frame, the candidate is "none".
- FSM evaluates once per frame end. States:
  - **IDLE**: candidate ≠ none → PRESS_WAIT, cnt=1, latch the candidate.
  - **PRESS_WAIT**:
    - Same candidate → cnt+1.
    - Different candidate → restart with cnt=1 and the new candidate.
    - None → IDLE.
    - When cnt reaches `DEBOUNCE_FRAMES` → PRESSED. On that same edge, `key` loads the latched code and `button_pressed` goes to 1. With `DEBOUNCE_FRAMES`=1 this happens directly from IDLE on the first frame.
  - **PRESSED**:
    - Any candidate (including a different key) → stay. `key` does not change.
    - None → RELEASE_WAIT, cnt=1; if `DEBOUNCE_FRAMES`=1, go to IDLE immediately.
  - **RELEASE_WAIT**:
    - None → cnt+1. When cnt reaches `DEBOUNCE_FRAMES` → IDLE with `button_pressed`←0.
    - Any candidate → PRESSED, with no new rising edge and `key` unchanged.
- `key` holds its last value after release until the next press is accepted.
- Multi-key presses resolve by the priority rule above. A second key pressed while one is held is ignored until full release.

## Timing
- Reset values (asynchronous): `row`=4'b1110, `key`=0, `button_pressed`=0, FSM=IDLE, dwell counter, row index and cnt all 0, synchronizer flops all 1.
- `key` and `button_pressed` are registered and change on the same edge. `key` is valid on the first cycle `button_pressed` is 1, as the consumer requires.
- Press latency: at most 2 sync cycles plus `DEBOUNCE_FRAMES` + 1 frames (frame = 4·`SCAN_DIV` cycles). Release latency: the same bound.
- Counter widths:
  - Dwell counter: $clog2(`SCAN_DIV`) bits.
  - cnt: $clog2(`DEBOUNCE_FRAMES`+1) bits, saturating.
  - Row index: 2 bits, wrapping.
- Reset asserted mid-press: `button_pressed` drops at once. After reset release, a still-held key is re-debounced from IDLE and produces a fresh rising edge.
- The scan never stalls. `row` advances regardless of FSM state.

## Structure
- Shared package `keypad_pkg`:
  - Key-code constants (KEY_A..KEY_D, KEY_STAR, KEY_HASH).
  - 4x4 code lookup function.
  - FSM state enum {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT}.
  - NUM_ROWS/NUM_COLS=4.
- Sub-module `keypad_sync`: 2-flop 4-bit synchronizer with reset-to-1. Scan, candidate and FSM logic stay in `keypad_scanner`.

## Test plan
All tests use `SCAN_DIV`=4 and `DEBOUNCE_FRAMES`=3 (frame = 16 cycles).
- Reset: hold `reset_n`=0 → `row`=1110, `key`=0, `button_pressed`=0. Release reset with `col`=1111 → `row` rotates 1110→1101→1011→0111 every 4 cycles, `button_pressed` stays 0.
- Clean press of '5': pull `col[1]` low only while `row[1]`=0, for 3 consecutive frames → `button_pressed` rises on the 3rd frame-end edge with `key`=5 on that same cycle. Hold for 10 frames → no further edges. Release → `button_pressed` falls after 3 empty frames, `key` stays 5.
- Bounce: '3' active in frame 1, absent in frame 2, active in frames 3–5 → assertion occurs only at the end of frame 5, `key`=3.
- Priority and change: press '1' and '9' together → `key`=1. Then drop '1' while keeping '9' → no new edge and `key` remains 1 until a full release.
- Release glitch: while holding '0', remove it for 2 frames, then restore it → `button_pressed` stays 1 throughout with no edge. Then release for 3 frames → falls.
- Reset mid-press: assert `reset_n` while '#' is held and pressed → `button_pressed`=0 immediately. After reset release with '#' still held → a new rising edge after 3 frames with `key`=15.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad constants, key-code map and FSM states
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} kp_state_e;

  // Physical [row][col] position to key code.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = KEY_A;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = KEY_B;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'd0;
      4'hE: code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad pins and debounced key outputs
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [7:0] key;
  logic       button_pressed;

  modport master (output row, output key, output button_pressed, input col);
  modport slave  (input row, input key, input button_pressed, output col);
endinterface

// File: rtl/keypad_sync.sv
// rtl/keypad_sync.sv - 2-flop 4-bit synchronizer, resets to all ones
module keypad_sync (
  input  logic       hwclk,
  input  logic       reset_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  // Two-stage capture of the asynchronous column lines; idle (pulled-up) value on reset.
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scan, frame candidate and debounce FSM
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 12000,
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic              hwclk,
  input  logic              reset_n,
  keypad_scanner_if.master  kp
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  logic [3:0]    col_sync;
  logic [DW-1:0] dwell_cnt;
  logic [1:0]    row_idx;
  logic [3:0]    row_q;
  logic          acc_valid;
  logic [3:0]    acc_code;
  logic          samp_valid;
  logic [3:0]    samp_code;
  logic          sample_now, frame_end;
  logic          cand_valid;
  logic [3:0]    cand_code;
  kp_state_e     state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]    latch_code, latch_n;
  logic [3:0]    key_q, key_n;
  logic          bp_q, bp_n;

  keypad_sync u_sync (
    .hwclk   (hwclk),
    .reset_n (reset_n),
    .d       (kp.col),
    .q       (col_sync)
  );

  assign sample_now = (dwell_cnt == DWELL_LAST);
  assign frame_end  = sample_now && (row_idx == 2'(NUM_ROWS - 1));
  // Earlier rows in the frame win; the current row only counts if none did.
  assign cand_valid = acc_valid | samp_valid;
  assign cand_code  = acc_valid ? acc_code : samp_code;
  assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  assign kp.row            = row_q;
  assign kp.key            = {4'b0000, key_q};
  assign kp.button_pressed = bp_q;

  // Lowest active column of the currently driven row.
  always_comb begin
    samp_valid = 1'b0;
    samp_code  = 4'd0;
    for (int c = NUM_COLS - 1; c >= 0; c--) begin
      if (!col_sync[c]) begin
        samp_valid = 1'b1;
        samp_code  = key_code(row_idx, 2'(c));
      end
    end
  end

  // Free-running row scan and per-frame accumulation of the first active key.
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      dwell_cnt <= '0;
      row_idx   <= 2'd0;
      row_q     <= 4'b1110;
      acc_valid <= 1'b0;
      acc_code  <= 4'd0;
    end else if (sample_now) begin
      dwell_cnt <= '0;
      row_idx   <= row_idx + 2'd1;
      row_q     <= {row_q[2:0], row_q[3]};
      if (row_idx == 2'd0 || !acc_valid) begin
        acc_valid <= samp_valid;
        acc_code  <= samp_code;
      end
    end else begin
      dwell_cnt <= dwell_cnt + DW'(1);
    end
  end

  // Debounce state register and registered key outputs.
  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      latch_code <= 4'd0;
      key_q      <= 4'd0;
      bp_q       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      latch_code <= latch_n;
      key_q      <= key_n;
      bp_q       <= bp_n;
    end
  end

  // Debounce next-state logic, evaluated once per frame end.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    latch_n = latch_code;
    key_n   = key_q;
    bp_n    = bp_q;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (cand_valid) begin
            latch_n = cand_code;
            if (CNT_ONE >= CNT_TARGET) begin
              state_n = PRESSED;
              cnt_n   = '0;
              key_n   = cand_code;
              bp_n    = 1'b1;
            end else begin
              state_n = PRESS_WAIT;
              cnt_n   = CNT_ONE;
            end
          end
        end
        PRESS_WAIT: begin
          if (!cand_valid) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (cand_code != latch_code) begin
            cnt_n   = CNT_ONE;
            latch_n = cand_code;
          end else if (cnt_inc >= CNT_TARGET) begin
            state_n = PRESSED;
            cnt_n   = '0;
            key_n   = latch_code;
            bp_n    = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        PRESSED: begin
          if (!cand_valid) begin
            if (CNT_ONE >= CNT_TARGET) begin
              state_n = IDLE;
              bp_n    = 1'b0;
            end else begin
              state_n = RELEASE_WAIT;
              cnt_n   = CNT_ONE;
            end
          end
        end
        RELEASE_WAIT: begin
          if (cand_valid) begin
            state_n = PRESSED;
            cnt_n   = '0;
          end else if (cnt_inc >= CNT_TARGET) begin
            state_n = IDLE;
            cnt_n   = '0;
            bp_n    = 1'b0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner
module tb_keypad_scanner;

  localparam logic [15:0] K1 = 16'h0001;
  localparam logic [15:0] K3 = 16'h0004;
  localparam logic [15:0] K5 = 16'h0020;
  localparam logic [15:0] K9 = 16'h0400;
  localparam logic [15:0] K0 = 16'h2000;
  localparam logic [15:0] KH = 16'h4000;

  typedef struct {
    logic       bp;
    logic [7:0] key;
    int         cyc;
  } exp_t;

  logic        hwclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] pressed = 16'h0000;
  logic [3:0]  col_v;
  logic        bp_prev = 1'b0;
  int          cyc;
  int          frame = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  exp_t        e;

  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
    .hwclk   (hwclk),
    .reset_n (reset_n),
    .kp      (kif)
  );

  always #5 hwclk = ~hwclk;

  // Keypad model: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_v = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[r*4+c] && !kif.row[r]) col_v[c] = 1'b0;
  end
  assign kif.col = col_v;

  // Edges since reset release.
  always @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic bp, input logic [3:0] code, input int frames_ahead);
    exp_t x;
    x.bp  = bp;
    x.key = {4'b0000, code};
    x.cyc = 16 * (frame + frames_ahead);
    exp_q.push_back(x);
  endtask

  task automatic run_frames(input logic [15:0] m, input int n);
    pressed = m;
    repeat (n) begin
      repeat (16) @(posedge hwclk);
      #1;
      frame++;
    end
  endtask

  // Monitor: every button_pressed edge outside reset must match the next expected entry.
  always @(negedge hwclk) begin
    if (reset_n && (kif.button_pressed !== bp_prev)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_edge", {31'd0, kif.button_pressed}, {31'd0, bp_prev});
      end else begin
        e = exp_q.pop_front();
        chk("edge_bp", {31'd0, kif.button_pressed}, {31'd0, e.bp});
        chk("edge_key", {24'd0, kif.key}, {24'd0, e.key});
        chk("edge_cycle", cyc, e.cyc);
      end
    end
    bp_prev = kif.button_pressed;
  end

  initial begin
    logic [3:0] er;
    repeat (3) @(posedge hwclk);
    #1;
    chk("reset_row", {28'd0, kif.row}, 32'h0000000E);
    chk("reset_key", {24'd0, kif.key}, 32'd0);
    chk("reset_bp", {31'd0, kif.button_pressed}, 32'd0);

    @(negedge hwclk);
    reset_n = 1'b1;
    frame = 0;
    for (int n = 1; n <= 16; n++) begin
      @(posedge hwclk);
      #1;
      er = ~(4'b0001 << ((n / 4) % 4));
      chk("row_scan", {28'd0, kif.row}, {28'd0, er});
    end
    chk("idle_bp", {31'd0, kif.button_pressed}, 32'd0);
    frame = 1;
    run_frames(16'h0000, 1);

    push_exp(1'b1, 4'd5, 3);
    run_frames(K5, 3);
    run_frames(K5, 10);
    push_exp(1'b0, 4'd5, 3);
    run_frames(16'h0000, 3);
    chk("key_holds_after_release", {24'd0, kif.key}, 32'd5);

    run_frames(K3, 1);
    run_frames(16'h0000, 1);
    push_exp(1'b1, 4'd3, 3);
    run_frames(K3, 3);
    push_exp(1'b0, 4'd3, 3);
    run_frames(16'h0000, 3);

    push_exp(1'b1, 4'd1, 3);
    run_frames(K1 | K9, 3);
    run_frames(K9, 4);
    chk("priority_key_held", {24'd0, kif.key}, 32'd1);
    chk("priority_bp_held", {31'd0, kif.button_pressed}, 32'd1);
    push_exp(1'b0, 4'd1, 3);
    run_frames(16'h0000, 3);

    push_exp(1'b1, 4'd0, 3);
    run_frames(K0, 3);
    run_frames(16'h0000, 2);
    chk("glitch_bp_held", {31'd0, kif.button_pressed}, 32'd1);
    run_frames(K0, 2);
    push_exp(1'b0, 4'd0, 3);
    run_frames(16'h0000, 3);

    push_exp(1'b1, 4'hF, 3);
    run_frames(KH, 3);
    run_frames(KH, 1);
    reset_n = 1'b0;
    #1;
    chk("midreset_bp", {31'd0, kif.button_pressed}, 32'd0);
    chk("midreset_key", {24'd0, kif.key}, 32'd0);
    chk("midreset_row", {28'd0, kif.row}, 32'h0000000E);
    repeat (2) @(posedge hwclk);
    @(negedge hwclk);
    reset_n = 1'b1;
    frame = 0;
    push_exp(1'b1, 4'hF, 3);
    run_frames(KH, 3);
    push_exp(1'b0, 4'hF, 3);
    run_frames(16'h0000, 3);

    run_frames(16'h0000, 1);
    chk("pending_expectations", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
